// File: rtl/mvau_weight_loader.sv
// Runtime loader that streams SIMD*TW-bit weight words into the per-PE weight
// memories over a shared write port, address-major (word n -> PE n%PE, addr n/PE).
module mvau_weight_loader #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int PE           = 2,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    load_start,
  input  logic                    in_v,
  input  logic [SIMD*TW-1:0]      in_wgt,
  input  logic                    in_last,
  output logic                    in_rdy,
  output logic [PE-1:0]           wmem_wen,
  output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
  output logic [SIMD*TW-1:0]      wmem_wdata,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int DW    = SIMD * TW;
  localparam int PE_BW = (PE > 1) ? $clog2(PE) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [PE_BW-1:0]        pe_cnt_reg;
  logic [WMEM_ADDR_BW-1:0] addr_cnt_reg;
  logic                    err_reg;
  logic [PE-1:0]           wen_reg;
  logic [PE-1:0]           wen_dec;
  logic [WMEM_ADDR_BW-1:0] waddr_reg;
  logic [DW-1:0]           wdata_reg;
  logic                    accept;
  logic                    last_pe;
  logic                    last_addr;
  logic                    final_word;

  assign last_pe    = (pe_cnt_reg == PE_BW'(PE - 1));
  assign last_addr  = (addr_cnt_reg == WMEM_ADDR_BW'(WMEM_DEPTH - 1));
  assign final_word = last_pe && last_addr;
  assign accept     = in_v && in_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < PE; gi++) begin : g_wen_dec
      assign wen_dec[gi] = (pe_cnt_reg == PE_BW'(gi));
    end
  endgenerate

  // Leaving LOAD on the final accept makes the final write coincide with DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load_start) state_next = LOAD;
      LOAD:    if (accept && final_word) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg    <= IDLE;
      pe_cnt_reg   <= '0;
      addr_cnt_reg <= '0;
      err_reg      <= 1'b0;
      wen_reg      <= '0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      wen_reg   <= '0;
      if (state_reg == IDLE && load_start) begin
        pe_cnt_reg   <= '0;
        addr_cnt_reg <= '0;
        err_reg      <= 1'b0;
      end
      if (accept) begin
        wen_reg   <= wen_dec;
        waddr_reg <= addr_cnt_reg;
        wdata_reg <= in_wgt;
        // in_last only flags framing; the word count alone ends the load
        if (in_last != final_word) err_reg <= 1'b1;
        if (last_pe) begin
          pe_cnt_reg   <= '0;
          addr_cnt_reg <= addr_cnt_reg + 1'b1;
        end else begin
          pe_cnt_reg <= pe_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign in_rdy     = (state_reg == LOAD);
  assign load_busy  = (state_reg != IDLE);
  assign load_done  = (state_reg == DONE);
  assign load_err   = err_reg;
  assign wmem_wen   = wen_reg;
  assign wmem_waddr = waddr_reg;
  assign wmem_wdata = wdata_reg;

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Randomized bench for mvau_weight_loader against a word-count reference model.
module tb_mvau_weight_loader;

  localparam int SIMD = 2, TW = 1, PE = 2, WMEM_DEPTH = 4, WMEM_ADDR_BW = 4;
  localparam int DW    = SIMD * TW;
  localparam int TOTAL = PE * WMEM_DEPTH;

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic                    load_start = 1'b0;
  logic                    in_v = 1'b0;
  logic [DW-1:0]           in_wgt = '0;
  logic                    in_last = 1'b0;
  logic                    in_rdy;
  logic [PE-1:0]           wmem_wen;
  logic [WMEM_ADDR_BW-1:0] wmem_waddr;
  logic [DW-1:0]           wmem_wdata;
  logic                    load_busy;
  logic                    load_done;
  logic                    load_err;

  always #5 aclk = ~aclk;

  mvau_weight_loader #(
    .SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_DEPTH(WMEM_DEPTH), .WMEM_ADDR_BW(WMEM_ADDR_BW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .load_start(load_start), .in_v(in_v),
    .in_wgt(in_wgt), .in_last(in_last), .in_rdy(in_rdy), .wmem_wen(wmem_wen),
    .wmem_waddr(wmem_waddr), .wmem_wdata(wmem_wdata), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a load is "active" plus a count of words taken so far.
  bit                      m_loading = 1'b0;
  int                      m_words = 0;
  bit                      m_err = 1'b0;
  logic [PE-1:0]           e_wen = '0;
  logic [WMEM_ADDR_BW-1:0] e_waddr = '0;
  logic [DW-1:0]           e_wdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    bit acc;
    e_wen = '0;
    if (!aresetn) begin
      m_loading = 1'b0;
      m_words   = 0;
      m_err     = 1'b0;
      e_waddr   = '0;
      e_wdata   = '0;
    end else begin
      acc = m_loading && (m_words < TOTAL) && in_v;
      if (acc) begin
        e_wen   = PE'(1 << (m_words % PE));
        e_waddr = WMEM_ADDR_BW'(m_words / PE);
        e_wdata = in_wgt;
        if (in_last != (m_words == TOTAL - 1)) m_err = 1'b1;
        m_words++;
      end else if (m_loading && m_words == TOTAL) begin
        m_loading = 1'b0;
      end else if (!m_loading && load_start) begin
        m_loading = 1'b1;
        m_words   = 0;
        m_err     = 1'b0;
      end
    end
    @(posedge aclk);
    #1;
    check("in_rdy", in_rdy, m_loading && (m_words < TOTAL));
    check("wen", wmem_wen, e_wen);
    check("waddr", wmem_waddr, e_waddr);
    check("wdata", wmem_wdata, e_wdata);
    check("busy", load_busy, m_loading);
    check("done", load_done, m_loading && (m_words == TOTAL));
    check("err", load_err, m_err);
    if (wmem_wen != '0)
      $display("write wen=%b addr=%0d data=%0h done=%0b err=%0b", wmem_wen, wmem_waddr,
               wmem_wdata, load_done, load_err);
  endtask

  task automatic do_load(input int vpct, input int last_idx, input bit late_start, input int rst_at);
    bit finished;
    finished   = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      in_v       = ($urandom_range(0, 99) < vpct);
      in_wgt     = DW'($urandom);
      in_last    = (m_words == last_idx);
      load_start = late_start && (m_words == 3);
      if (rst_at > 0 && m_words == rst_at) begin
        aresetn = 1'b0;
        tick();
        aresetn  = 1'b1;
        finished = 1'b1;
      end else begin
        tick();
        if (m_loading && m_words == TOTAL) finished = 1'b1;
      end
    end
    check("load_timeout", finished, 1);
    load_start = 1'b0;
    in_last    = 1'b0;
    in_v       = 1'b1;
    tick();
    in_v = 1'b0;
    tick();
  endtask

  initial begin
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();

    in_v   = 1'b1;
    in_wgt = DW'(3);
    repeat (4) tick();
    in_v = 1'b0;

    do_load(100, TOTAL - 1, 1'b0, 0);
    do_load(40, TOTAL - 1, 1'b0, 0);
    do_load(100, 2, 1'b0, 0);
    do_load(70, -1, 1'b0, 0);
    do_load(100, TOTAL - 1, 1'b0, 0);
    do_load(100, TOTAL - 1, 1'b1, 0);
    do_load(100, TOTAL - 1, 1'b0, 5);
    do_load(60, TOTAL - 1, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      do_load($urandom_range(30, 100),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, TOTAL - 1) : TOTAL - 1,
              1'(($urandom_range(0, 1))), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
